// File: rtl/bin_to_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one shift per clock).
// Digit outputs hold the previous result until a conversion completes.
module bin_to_bcd #(
    parameter int unsigned BW = 8,
    parameter int unsigned DL = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [BW-1:0] bin,
    output logic          busy,
    output logic          done,
    output logic [DL-1:0] ones,
    output logic [DL-1:0] ten,
    output logic [DL-1:0] hund
);

    localparam int unsigned SW = 12;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [BW-1:0] r_bin;
    logic [SW-1:0] r_scratch;
    logic [SW-1:0] w_adj;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic [DL-1:0] r_ones;
    logic [DL-1:0] r_ten;
    logic [DL-1:0] r_hund;
    logic          w_unused;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (r_cnt == CNT_LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Add-3 adjust per nibble; nibbles are independent, no carry between them
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 3; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // The hundreds nibble never exceeds 2, so its MSB never shifts out
    assign w_unused = w_adj[SW-1];

    // Datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_ones    <= '0;
            r_ten     <= '0;
            r_hund    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin     <= bin;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                    end
                end
                SHIFT: begin
                    r_scratch <= {w_adj[SW-2:0], r_bin[BW-1]};
                    r_bin     <= {r_bin[BW-2:0], 1'b0};
                    r_cnt     <= r_cnt + CW'(1);
                end
                DONE: begin
                    r_ones <= DL'(r_scratch[3:0]);
                    r_ten  <= DL'(r_scratch[7:4]);
                    r_hund <= DL'(r_scratch[11:8]);
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign ones = r_ones;
    assign ten  = r_ten;
    assign hund = r_hund;

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter: BW, default 8, binary input width; only 8 is supported.
REQ-002 Parameter: DL, default 4, width of each BCD digit output.
REQ-003 Port: CLK  input  1  system clock; all state changes on rising edge.
REQ-004 Port: RST  input  1  reset, synchronous and active-high.
REQ-005 Port: start  input  1  conversion request, sampled on rising CLK edge.
REQ-006 Port: bin  input  BW  unsigned binary value 0..255, sampled when start is accepted.
REQ-007 Port: busy  output  1  high while a conversion is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking new digits on outputs.
REQ-009 Port: ones  output  DL  BCD units digit 0..9.
REQ-010 Port: ten  output  DL  BCD tens digit 0..9.
REQ-011 Port: hund  output  DL  BCD hundreds digit 0..2.

Function
REQ-012 The block SHALL convert using sequential shift-add-3 (double dabble): one shift per clock, 8 shifts per conversion.
REQ-013 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, with IDLE as the reset state.
REQ-014 IDLE: start=1 at edge N SHALL capture bin, clear the 12-bit BCD scratch register and the shift counter, and move to SHIFT.
REQ-015 SHIFT: each edge SHALL first add 3 to every scratch nibble >= 5, then shift {scratch, binary} left by 1 and increment the counter.
REQ-016 SHIFT SHALL move to DONE on the edge performing the 8th shift (edge N+8).
REQ-017 DONE: edge N+9 SHALL load ones/ten/hund from scratch nibbles [3:0]/[7:4]/[11:8], set done=1, and return to IDLE.
REQ-018 done SHALL be registered, high exactly one cycle (after edge N+9), and cleared at edge N+10.
REQ-019 busy SHALL be combinational, (state != IDLE): high from edge N until edge N+9.
REQ-020 start while busy=1 SHALL be ignored, with no queuing and no effect on the running conversion.
REQ-021 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted as a new request.
REQ-022 bin changes after acceptance SHALL NOT affect the running conversion.
REQ-023 ones/ten/hund SHALL hold the previous result throughout a conversion and change only at the DONE edge, keeping downstream display glitch-free.
REQ-024 The counter SHALL be 4 bits, and the add-3 adjust SHALL be 4 bits per nibble with no carry between nibbles.
REQ-025 For every input 0..255, outputs SHALL satisfy hund*100 + ten*10 + ones == bin, with each digit <= 9 and hund <= 2.

Reset
REQ-026 RST=1 at a rising edge SHALL force state=IDLE, done=0, ones=ten=hund=0, scratch=0 and counter=0, overriding start.
REQ-027 RST asserted mid-conversion SHALL abort it with no done pulse and outputs at 0; the first start after RST release SHALL begin a fresh conversion.
REQ-028 busy SHALL read 0 in the cycle after any reset edge.

Verification
REQ-029 Reset, then start with bin=255 -> busy high for 9 cycles, done pulse 1 cycle at edge N+9, hund=2, ten=5, ones=5.
REQ-030 bin=0, then bin=100, then bin=9 -> results (0,0,0), (1,0,0), (0,0,9); outputs unchanged while busy.
REQ-031 Start bin=37, then at N+3 pulse start with bin=200 -> second request ignored, result (0,3,7), only one done pulse.
REQ-032 Start bin=128, assert RST at N+4 -> no done, outputs 0, busy 0; then start bin=64 -> (0,6,4).
REQ-033 Back-to-back: start bin=19, then start again in the done cycle with bin=250 -> (0,1,9) followed 10 cycles later by (2,5,0).
REQ-034 Exhaustive sweep 0..255 against a reference model -> all digit triples match, done count == 256.
